instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction-fetch stage of the single-issue MIPS pipeline. Holds the PC and drives the
//  word address of the asynchronous instruction ROM. Captures the returned 32-bit word
//  into the IF/ID pipeline register, with handling for stall, branch/jump redirect and
//  halt (syscall). Also keeps a count of retired fetches for the display path.
// PARAMETERS
//  AWIDTH    10            ROM word-address width; the ROM holds 2**AWIDTH words
//  DWIDTH    32            instruction width
//  RESET_PC  32'h00000000  byte address fetched first after reset
// PORTS
//  clk          in   1       system clock; all state updates on the rising edge
//  rst_n        in   1       synchronous reset, active-low
//  stall        in   1       hazard unit: hold the PC and the IF/ID register
//  redirect     in   1       taken branch or jump from EX
//  redirect_pc  in   32      byte target of the redirect
//  halt_req     in   1       syscall/halt decoded downstream
//  rom_raddr    out  AWIDTH  word address to the ROM
//  rom_rdata    in   DWIDTH  ROM data, valid in the same cycle (combinational read)
//  id_valid     out  1       IF/ID register holds a live instruction
//  id_instr     out  DWIDTH  IF/ID instruction
//  id_pc        out  32      byte PC of id_instr
//  id_pc_plus4  out  32      id_pc + 4, for link and branch offsets
//  halted       out  1       fetch is permanently stopped
//  fetch_cnt    out  32      number of instructions loaded into IF/ID; saturating
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
//  - Reset (rst_n==0 at a rising edge): pc<=RESET_PC, id_valid<=0, id_instr<=0, id_pc<=0,
//    id_pc_plus4<=0, fetch_cnt<=0, state<=RUN, halted<=0.
//  - rom_raddr = pc[AWIDTH+1:2], purely combinational. PC bits above AWIDTH+1 are ignored,
//    so the ROM aliases modulo 2**(AWIDTH+2) bytes. pc[1:0] is always 00.
//  - State machine: RUN and HALTED.
//  - RUN: per-edge priority is halt_req > redirect > stall > normal.
//    - halt_req: go to HALTED. pc holds, id_valid<=0, halted<=1.
//    - redirect: pc<={redirect_pc[31:2],2'b00}; id_valid<=0, which squashes the word
//      fetched this cycle. Redirect wins over a simultaneous stall. fetch_cnt unchanged.
//    - stall: pc, id_*, and fetch_cnt all hold.
//    - normal: id_instr<=rom_rdata, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
//      fetch_cnt increments by 1 and saturates at 32'hFFFFFFFF.
//  - HALTED: all registers hold, except id_valid, which is held at 0. stall, redirect and
//    halt_req are ignored. Only rst_n exits; the next cycle after reset fetches RESET_PC.
//  - Latency: the word at address pc appears on id_instr one edge after pc is presented.
//    Redirect penalty is one bubble: the target is fetched the cycle after the edge.
//  - Arithmetic: pc+4 is 32-bit modulo. 32'hFFFFFFFC+4 wraps to 0 with no flag.
//  - Reset mid-stall or mid-redirect: reset wins unconditionally, and no partial update
//    survives.
//  - Misaligned redirect_pc: the low two bits are dropped silently.
// TESTING
//  1 Reset: hold rst_n=0 for 2 cycles, release -> rom_raddr=0, id_valid=0, fetch_cnt=0,
//    halted=0.
//  2 Sequential fetch: ROM[0..3]=A0..A3, 4 free cycles -> id_instr A0,A1,A2,A3;
//    id_pc 0,4,8,C; fetch_cnt=4.
//  3 Stall: stall=1 for 3 cycles after A1 is captured -> id_instr=A1 and rom_raddr=2
//    held; A2 follows on release.
//  4 Redirect with stall: redirect=1, stall=1, redirect_pc=32'h42 ->
//    next edge: id_valid=0, rom_raddr=16;
//    following edge: id_pc=32'h40, id_instr=ROM[16].
//  5 Halt: halt_req=1 together with redirect=1 -> halted=1, id_valid=0, pc unchanged.
//    Further redirect/stall pulses leave pc and fetch_cnt unchanged. rst_n=0 recovers.
//  6 Alias/wrap: redirect_pc=32'h00000FFC, AWIDTH=10 -> rom_raddr=1023, then next
//    rom_raddr=0 with pc=32'h1000. redirect_pc=32'hFFFFFFFC -> pc wraps to 0.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS instruction-fetch stage: PC, ROM address, IF/ID register, halt FSM
// Redirect beats stall; HALTED is left only through reset.
module instr_fetch #(
   parameter int          AWIDTH   = 10,
   parameter int          DWIDTH   = 32,
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   input  logic              halt_req,
   output logic [AWIDTH-1:0] rom_raddr,
   input  logic [DWIDTH-1:0] rom_rdata,
   output logic              id_valid,
   output logic [DWIDTH-1:0] id_instr,
   output logic [31:0]       id_pc,
   output logic [31:0]       id_pc_plus4,
   output logic              halted,
   output logic [31:0]       fetch_cnt
);

   typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [31:0]       r_pc;
   logic              r_valid;
   logic [DWIDTH-1:0] r_instr;
   logic [31:0]       r_id_pc;
   logic [31:0]       r_id_pc4;
   logic [31:0]       r_cnt;

   logic [31:0]       w_pc_nxt;
   logic [31:0]       w_pc_plus4;
   logic [31:0]       w_redirect_aligned;
   logic              w_valid_nxt;
   logic              w_capture;
   logic [31:0]       w_cnt_nxt;

   assign w_pc_plus4         = r_pc + 32'd4;
   assign w_redirect_aligned = redirect_pc & ~32'h3;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_RUN && halt_req) begin
         w_state_nxt = S_HALTED;
      end
   end

   // Datapath controls: halt_req > redirect > stall > normal fetch.
   always_comb begin
      w_pc_nxt    = r_pc;
      w_valid_nxt = r_valid;
      w_capture   = 1'b0;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_HALTED: begin
            w_valid_nxt = 1'b0;
         end
         default: begin
            if (halt_req) begin
               w_valid_nxt = 1'b0;
            end else if (redirect) begin
               w_pc_nxt    = w_redirect_aligned;
               w_valid_nxt = 1'b0;
            end else if (!stall) begin
               w_capture   = 1'b1;
               w_pc_nxt    = w_pc_plus4;
               w_valid_nxt = 1'b1;
               if (r_cnt != 32'hFFFFFFFF) begin
                  w_cnt_nxt = r_cnt + 32'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc     <= RESET_PC;
         r_valid  <= 1'b0;
         r_instr  <= '0;
         r_id_pc  <= 32'h0;
         r_id_pc4 <= 32'h0;
         r_cnt    <= 32'h0;
      end else begin
         r_pc    <= w_pc_nxt;
         r_valid <= w_valid_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_capture) begin
            r_instr  <= rom_rdata;
            r_id_pc  <= r_pc;
            r_id_pc4 <= w_pc_plus4;
         end
      end
   end

   assign rom_raddr   = r_pc[AWIDTH+1:2];
   assign id_valid    = r_valid;
   assign id_instr    = r_instr;
   assign id_pc       = r_id_pc;
   assign id_pc_plus4 = r_id_pc4;
   assign halted      = (r_state == S_HALTED);
   assign fetch_cnt   = r_cnt;

endmodule
